data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_array.sv | 35 +++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder slice: default geometry,
//   FSM state encoding and the captured-request record.
//   No ports (package).
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int DEFAULT_ADDR_BITS   = 8;
  localparam int DEFAULT_WAIT_STATES = 2;

  // State encoding is fixed so that older tools and probes reading the raw
  // state vector keep working.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // One CPU request as seen on the bus, either live or latched at acceptance.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        is_read;
    logic        is_write;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_array
//   Single-port RAM, 16-bit words, 2**ADDR_BITS entries. Writes happen on the
//   rising clock edge when we is high; contents are never reset.
//   Ports:
//     clk    - clock
//     we     - write enable
//     addr   - word address
//     wdata  - write data
//     rdata  - read data for addr
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [2**ADDR_BITS];

  // Write port: the responder asserts we only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read is combinational so the responder can register the word on the same
  // edge that finishes the access, even with zero wait states.
  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Wait-stated data memory for the CPU. A request held on mem_read/mem_write
//   is captured in IDLE, spends WAIT_STATES cycles in ACCESS, then completes
//   in RESP with a one-cycle mem_ready (and mem_error on a bad request).
//   Ports:
//     clk            - clock, rising edge
//     pc_reset       - asynchronous active-high reset
//     mem_address    - word address from the CPU
//     mem_write_data - store data
//     mem_read       - load request, held until mem_ready
//     mem_write      - store request, held until mem_ready
//     read_data      - registered load result
//     mem_ready      - one-cycle completion pulse
//     mem_error      - one-cycle error pulse, coincident with mem_ready
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]           state;
  logic [3:0]           wait_count;
  mem_req_t             captured_req;
  mem_req_t             live_req;
  mem_req_t             active_req;
  logic                 accept;
  logic                 enter_resp;
  logic                 req_error;
  logic                 array_we;
  logic [ADDR_BITS-1:0] array_addr;
  logic [15:0]          array_rdata;

  assign live_req = '{addr: mem_address, wdata: mem_write_data,
                      is_read: mem_read, is_write: mem_write};

  // With zero wait states the access completes on the accepting edge, before
  // the captured copy exists, so IDLE works from the live bus. Everywhere
  // else only the captured copy is used and the bus is ignored.
  assign active_req = (state == ST_IDLE) ? live_req : captured_req;

  assign accept     = (state == ST_IDLE) && (mem_read || mem_write);
  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state == ST_ACCESS) && (wait_count == 4'd1));

  // Any address bit above the implemented array, or a simultaneous load and
  // store, is rejected.
  assign req_error  = ((active_req.addr >> ADDR_BITS) != 16'd0) ||
                      (active_req.is_read && active_req.is_write);

  assign array_addr = active_req.addr[ADDR_BITS-1:0];
  assign array_we   = enter_resp && active_req.is_write && !req_error;

  mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem_array (
    .clk   (clk),
    .we    (array_we),
    .addr  (array_addr),
    .wdata (active_req.wdata),
    .rdata (array_rdata)
  );

  // Sequencer: IDLE -> ACCESS (WAIT_STATES cycles) -> RESP -> IDLE. The
  // counter is loaded with WAIT_STATES on acceptance and ACCESS ends on the
  // edge where it reads 1.
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      state        <= ST_IDLE;
      wait_count   <= 4'd0;
      captured_req <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            captured_req <= live_req;
            wait_count   <= WAIT_LOAD;
            state        <= (WAIT_STATES == 0) ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_count == 4'd1) begin
            wait_count <= 4'd0;
            state      <= ST_RESP;
          end else begin
            wait_count <= wait_count - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response outputs are registered on the edge entering RESP, so they are
  // valid for exactly the RESP cycle; an error always clears read_data.
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      read_data <= 16'h0000;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      mem_ready <= enter_resp;
      mem_error <= enter_resp && req_error;
      if (enter_resp) begin
        if (req_error) begin
          read_data <= 16'h0000;
        end else if (active_req.is_read) begin
          read_data <= array_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. Instance 0 uses the default
//   two wait states, instance 1 is built with zero wait states. Expected
//   responses are queued as each request is driven and checked when mem_ready
//   appears.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  logic        clk;
  logic        pc_reset;
  logic [15:0] addr_in   [2];
  logic [15:0] wdata_in  [2];
  logic        rd_in     [2];
  logic        wr_in     [2];
  logic [15:0] rdata_out [2];
  logic        ready_out [2];
  logic        error_out [2];

  exp_t        sb_q[$];
  logic [15:0] model_mem   [2][256];
  logic [15:0] model_rdata [2];
  int          num_compared;
  int          num_mismatched;
  int          cycles;

  data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) dut (
    .clk            (clk),
    .pc_reset       (pc_reset),
    .mem_address    (addr_in[0]),
    .mem_write_data (wdata_in[0]),
    .mem_read       (rd_in[0]),
    .mem_write      (wr_in[0]),
    .read_data      (rdata_out[0]),
    .mem_ready      (ready_out[0]),
    .mem_error      (error_out[0])
  );

  data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dut_fast (
    .clk            (clk),
    .pc_reset       (pc_reset),
    .mem_address    (addr_in[1]),
    .mem_write_data (wdata_in[1]),
    .mem_read       (rd_in[1]),
    .mem_write      (wr_in[1]),
    .read_data      (rdata_out[1]),
    .mem_ready      (ready_out[1]),
    .mem_error      (error_out[1])
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the bench itself gets stuck
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one request to instance d and queues the response the reference
  // model predicts for it.
  task automatic applyStimulus(input int d, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic rd,
                               input logic wr, input string tag);
    exp_t       e;
    logic       err;
    logic [7:0] idx;
    addr_in[d]  = addr;
    wdata_in[d] = wdata;
    rd_in[d]    = rd;
    wr_in[d]    = wr;
    idx = addr[7:0];
    err = (addr[15:8] != 8'h00) || (rd && wr);
    if (err) begin
      model_rdata[d] = 16'h0000;
    end else if (wr) begin
      model_mem[d][idx] = wdata;
    end else if (rd) begin
      model_rdata[d] = model_mem[d][idx];
    end
    e.rdata = model_rdata[d];
    e.err   = err;
    e.tag   = tag;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for mem_ready on instance d, returns the number of
  // negedges waited and checks the response against the scoreboard head.
  task automatic waitResponse(input int d, output int n);
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ready_out[d] !== 1'b1) && (n < 20));
    if (ready_out[d] !== 1'b1) begin
      checkOutput("ready_timeout", {31'd0, ready_out[d]}, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      checkOutput("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({e.tag, "_rdata"}, {16'd0, rdata_out[d]}, {16'd0, e.rdata});
      checkOutput({e.tag, "_err"}, {31'd0, error_out[d]}, {31'd0, e.err});
    end
  endtask

  // Drops the request and confirms the response pulses last one cycle.
  task automatic finishTxn(input int d);
    rd_in[d] = 1'b0;
    wr_in[d] = 1'b0;
    @(negedge clk);
    checkOutput("ready_pulse", {31'd0, ready_out[d]}, 32'd0);
    checkOutput("error_pulse", {31'd0, error_out[d]}, 32'd0);
  endtask

  // Full single transaction with a latency check.
  task automatic doTxn(input int d, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic rd,
                       input logic wr, input string tag, input int lat);
    int n;
    applyStimulus(d, addr, wdata, rd, wr, tag);
    waitResponse(d, n);
    checkOutput({tag, "_lat"}, n, lat);
    finishTxn(d);
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    pc_reset       = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr_in[d]     = 16'h0000;
      wdata_in[d]    = 16'h0000;
      rd_in[d]       = 1'b0;
      wr_in[d]       = 1'b0;
      model_rdata[d] = 16'h0000;
    end

    // Reset state of both instances
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_rdata", {16'd0, rdata_out[d]}, 32'h0);
      checkOutput("rst_ready", {31'd0, ready_out[d]}, 32'h0);
      checkOutput("rst_error", {31'd0, error_out[d]}, 32'h0);
    end
    checkOutput("rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    pc_reset = 1'b0;

    // Store then load, three cycles each
    doTxn(0, 16'h0010, 16'hBEEF, 1'b0, 1'b1, "st_10", 3);
    doTxn(0, 16'h0010, 16'h0000, 1'b1, 1'b0, "ld_10", 3);

    // Preload locations used below
    doTxn(0, 16'h0001, 16'h1111, 1'b0, 1'b1, "st_01", 3);
    doTxn(0, 16'h0002, 16'h2222, 1'b0, 1'b1, "st_02", 3);
    doTxn(0, 16'h0000, 16'h0F0F, 1'b0, 1'b1, "st_00", 3);
    doTxn(0, 16'h0005, 16'h5A5A, 1'b0, 1'b1, "st_05", 3);
    doTxn(0, 16'h0020, 16'h1234, 1'b0, 1'b1, "st_20", 3);

    // Back-to-back loads with the request held: responses four cycles apart
    applyStimulus(0, 16'h0001, 16'h0000, 1'b1, 1'b0, "b2b_01");
    waitResponse(0, cycles);
    checkOutput("b2b_01_lat", cycles, 3);
    applyStimulus(0, 16'h0002, 16'h0000, 1'b1, 1'b0, "b2b_02");
    waitResponse(0, cycles);
    checkOutput("b2b_interval", cycles, 4);
    finishTxn(0);

    // Out-of-range store is rejected and leaves the array alone
    doTxn(0, 16'h0100, 16'h5555, 1'b0, 1'b1, "st_oob", 3);
    doTxn(0, 16'h0000, 16'h0000, 1'b1, 1'b0, "ld_00", 3);

    // Simultaneous load and store is rejected
    doTxn(0, 16'h0005, 16'hFFFF, 1'b1, 1'b1, "rdwr_05", 3);
    doTxn(0, 16'h0005, 16'h0000, 1'b1, 1'b0, "ld_05", 3);

    // Store followed directly by a load of the same word
    applyStimulus(0, 16'h0040, 16'hCAFE, 1'b0, 1'b1, "st_40");
    waitResponse(0, cycles);
    applyStimulus(0, 16'h0040, 16'h0000, 1'b1, 1'b0, "raw_40");
    waitResponse(0, cycles);
    checkOutput("raw_interval", cycles, 4);
    finishTxn(0);

    // Reset in the second ACCESS cycle of a store aborts it silently
    addr_in[0]  = 16'h0020;
    wdata_in[0] = 16'hAAAA;
    wr_in[0]    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    pc_reset = 1'b1;
    wr_in[0] = 1'b0;
    #1;
    checkOutput("abort_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    checkOutput("abort_count", {28'd0, dut.wait_count}, 32'd0);
    checkOutput("abort_rdata", {16'd0, rdata_out[0]}, 32'h0);
    checkOutput("abort_ready", {31'd0, ready_out[0]}, 32'h0);
    model_rdata[0] = 16'h0000;
    model_rdata[1] = 16'h0000;
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_no_ready", {31'd0, ready_out[0]}, 32'h0);
    end
    pc_reset = 1'b0;
    // Accepted on the first edge after reset release
    doTxn(0, 16'h0020, 16'h0000, 1'b1, 1'b0, "ld_20", 3);

    // Zero-wait-state instance
    doTxn(1, 16'h0003, 16'h3333, 1'b0, 1'b1, "f_st_03", 1);
    applyStimulus(1, 16'h0003, 16'h0000, 1'b1, 1'b0, "f_ld_03");
    waitResponse(1, cycles);
    checkOutput("f_ld_03_lat", cycles, 1);
    applyStimulus(1, 16'h0003, 16'h0000, 1'b1, 1'b0, "f_ld_03b");
    waitResponse(1, cycles);
    checkOutput("f_interval", cycles, 2);
    finishTxn(1);
    doTxn(1, 16'hFF03, 16'h0000, 1'b1, 1'b0, "f_oob", 1);

    checkOutput("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             num_compared, num_mismatched);
    $finish;
  end

endmodule
